// File: rtl/approx_pkg.sv
// approx_pkg: ALU mode codes and isqrt sequencer state encodings shared with the approximation ALU.
package approx_pkg;
  typedef enum logic [2:0] {
    ADD_ONE  = 3'd0,
    SUB_ONE  = 3'd1,
    ADD_SUB  = 3'd2,
    MULTIPLY = 3'd3,
    ALU_IDLE = 3'd4
  } alu_mode_e;
  typedef enum logic [2:0] {
    S_IDLE, S_SUB, S_CHK, S_INC_CNT, S_INC_ODD1, S_INC_ODD2, S_VERIFY, S_DONE
  } isqrt_state_e;
endpackage

// File: rtl/isqrt_seq_ctrl.sv
// isqrt_seq_ctrl: floor(sqrt(x)) and remainder by odd-number subtraction, sequencing the approximation ALU.
// Define ISQRT_SELF_CHECK_EN to add a VERIFY state re-checking root*root + rem == x via the ALU multiplier.
module isqrt_seq_ctrl
  import approx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] x_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  root_o,
  output logic [DATA_W-1:0] rem_o,
  output logic              chk_fail_o,
  output logic [DATA_W-1:0] alu_op_a_o,
  output logic [DATA_W-1:0] alu_op_b_o,
  output logic              alu_sigma_n_o,
  output logic [2:0]        alu_mode_o,
  input  logic [RES_W-1:0]  alu_res_i
);
`ifdef ISQRT_SELF_CHECK_EN
  localparam isqrt_state_e S_FIN = S_VERIFY;
`else
  localparam isqrt_state_e S_FIN = S_DONE;
`endif
  isqrt_state_e state_q, state_d;
  logic [DATA_W-1:0] r_q, r_d, odd_q, odd_d, tmp_q, tmp_d, x_q, x_d, rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, root_q, root_d;
  logic err_q, err_d, chk_q, chk_d, busy_q, busy_d, done_q, done_d, sn_q, sn_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  alu_mode_e mode_q, mode_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_i) state_d = x_i[DATA_W-1] ? S_DONE : S_SUB;
      S_SUB:      state_d = S_CHK;
      S_CHK:      state_d = tmp_q[DATA_W-1] ? S_FIN : S_INC_CNT;
      S_INC_CNT:  state_d = S_INC_ODD1;
      S_INC_ODD1: state_d = S_INC_ODD2;
      S_INC_ODD2: state_d = S_SUB;
      S_VERIFY:   state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end
  always_comb begin
    r_d = r_q;
    odd_d = odd_q;
    cnt_d = cnt_q;
    tmp_d = tmp_q;
    x_d = x_q;
    err_d = err_q;
    root_d = root_q;
    rem_d = rem_q;
    chk_d = chk_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        x_d = x_i;
        r_d = x_i;
        odd_d = DATA_W'(1);
        cnt_d = '0;
        err_d = x_i[DATA_W-1];
        root_d = '0;
        rem_d = '0;
        chk_d = 1'b0;
      end
      S_SUB: tmp_d = alu_res_i[DATA_W-1:0];
      S_CHK: if (tmp_q[DATA_W-1]) begin
        rem_d = r_q;
        root_d = cnt_q;
      end else r_d = tmp_q;
      S_INC_CNT: cnt_d = alu_res_i[CNT_W-1:0];
      S_INC_ODD1, S_INC_ODD2: odd_d = alu_res_i[DATA_W-1:0];
`ifdef ISQRT_SELF_CHECK_EN
      S_VERIFY: chk_d = (alu_res_i + RES_W'(rem_q)) != RES_W'(x_q);
`endif
      default: ;
    endcase
  end
  // ALU operands are registered for the state being entered, so they read the updated (_d) values
  always_comb begin
    mode_d = ALU_IDLE;
    a_d = '0;
    b_d = '0;
    sn_d = 1'b0;
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
    case (state_d)
      S_SUB: begin
        mode_d = ADD_SUB;
        a_d = r_d;
        b_d = odd_d;
        sn_d = 1'b1;
      end
      S_INC_CNT: begin
        mode_d = ADD_ONE;
        a_d = DATA_W'(cnt_d);
      end
      S_INC_ODD1, S_INC_ODD2: begin
        mode_d = ADD_ONE;
        a_d = odd_d;
      end
      S_VERIFY: begin
        mode_d = MULTIPLY;
        a_d = DATA_W'(cnt_d);
        b_d = DATA_W'(cnt_d);
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_q <= '0;
      odd_q <= '0;
      cnt_q <= '0;
      tmp_q <= '0;
      x_q <= '0;
      err_q <= 1'b0;
      root_q <= '0;
      rem_q <= '0;
      chk_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mode_q <= ALU_IDLE;
      a_q <= '0;
      b_q <= '0;
      sn_q <= 1'b0;
    end else begin
      r_q <= r_d;
      odd_q <= odd_d;
      cnt_q <= cnt_d;
      tmp_q <= tmp_d;
      x_q <= x_d;
      err_q <= err_d;
      root_q <= root_d;
      rem_q <= rem_d;
      chk_q <= chk_d;
      busy_q <= busy_d;
      done_q <= done_d;
      mode_q <= mode_d;
      a_q <= a_d;
      b_q <= b_d;
      sn_q <= sn_d;
    end
`ifndef ISQRT_SELF_CHECK_EN
  logic unused_ok;
  assign unused_ok = ^{alu_res_i[RES_W-1:DATA_W], x_q};
`endif
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o = err_q;
  assign root_o = root_q;
  assign rem_o = rem_q;
  assign chk_fail_o = chk_q;
  assign alu_op_a_o = a_q;
  assign alu_op_b_o = b_q;
  assign alu_sigma_n_o = sn_q;
  assign alu_mode_o = mode_q;
endmodule
